// File: rtl/fp16_zero_skip_encoder_if.sv
// fp16_zero_skip_encoder_if: activation input stream and tagged nonzero output stream
interface fp16_zero_skip_encoder_if #(parameter int OFF_W = 4);
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      out_data;
    logic [OFF_W-1:0] out_offset;
    logic             out_last;
    logic             out_empty;
    logic             out_valid;
    logic             out_ready;
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_offset, out_last, out_empty, out_valid
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_offset, out_last, out_empty, out_valid
    );
endinterface

// File: rtl/fp16_zero_skip_encoder.sv
// fp16_zero_skip_encoder: drops zero activations per brick, emits offset-tagged nonzeros via a FIFO
module fp16_zero_skip_encoder #(
    parameter int BRICK = 16,
    parameter int OFF_W = $clog2(BRICK),
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    fp16_zero_skip_encoder_if.slave bus,
    output logic [CNT_W-1:0]      zero_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 16 + OFF_W + 2;
    typedef enum logic {RUN, FLUSH} state_t;
    state_t           state, state_n;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic [OFF_W-1:0] pos, hold_off, hoff_n;
    logic [15:0]      hold_val, hval_n;
    logic             hold_v, hv_n;
    logic             full, acc, pop, zero, at_end, push, zc_inc;
    logic [EW-1:0]    entry;
    assign full         = cnt == (AW+1)'(DEPTH);
    assign bus.in_ready = !rst && state == RUN && !full;
    assign acc          = bus.in_valid && bus.in_ready;
    assign bus.out_valid = cnt != '0;
    assign pop          = bus.out_valid && bus.out_ready;
    assign zero         = bus.in_data[14:0] == 15'h0;
    assign at_end       = pos == OFF_W'(BRICK - 1);
    assign {bus.out_data, bus.out_offset, bus.out_last, bus.out_empty} = bus.out_valid ? mem[rp] : '0;
    // Entry layout: {value, offset, last, empty}; hold delays each nonzero so last can be known
    always_comb begin
        state_n = state;
        push    = 1'b0;
        entry   = '0;
        hv_n    = hold_v;
        hval_n  = hold_val;
        hoff_n  = hold_off;
        zc_inc  = 1'b0;
        if (state == FLUSH) begin
            if (!full) begin
                push    = 1'b1;
                entry   = {hold_val, hold_off, 2'b10};
                hv_n    = 1'b0;
                state_n = RUN;
            end
        end else if (acc) begin
            zc_inc = zero;
            if (!at_end) begin
                if (!zero) begin
                    push   = hold_v;
                    entry  = {hold_val, hold_off, 2'b00};
                    hv_n   = 1'b1;
                    hval_n = bus.in_data;
                    hoff_n = pos;
                end
            end else if (zero) begin
                push  = 1'b1;
                entry = hold_v ? {hold_val, hold_off, 2'b10} : {16'h0, {OFF_W{1'b0}}, 2'b11};
                hv_n  = 1'b0;
            end else if (hold_v) begin
                push    = 1'b1;
                entry   = {hold_val, hold_off, 2'b00};
                hval_n  = bus.in_data;
                hoff_n  = pos;
                state_n = FLUSH;
            end else begin
                push  = 1'b1;
                entry = {bus.in_data, pos, 2'b10};
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pos        <= '0;
            hold_v     <= 1'b0;
            hold_val   <= '0;
            hold_off   <= '0;
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            zero_count <= '0;
        end else begin
            state    <= state_n;
            hold_v   <= hv_n;
            hold_val <= hval_n;
            hold_off <= hoff_n;
            if (acc) pos <= pos + 1'b1;
            wp  <= wp + AW'(push);
            rp  <= rp + AW'(pop);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (zc_inc && !(&zero_count)) zero_count <= zero_count + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= entry;
    end
endmodule

// File: tb/tb_fp16_zero_skip_encoder.sv
// tb_fp16_zero_skip_encoder: directed and randomized checks against a brick-level reference model
module tb_fp16_zero_skip_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fp16_zero_skip_encoder_if #(.OFF_W(4)) bus ();
    fp16_zero_skip_encoder_if #(.OFF_W(4)) bus2 ();
    logic [31:0] zc;
    logic [3:0]  zc2;
    fp16_zero_skip_encoder dut (.clk(clk), .rst(rst), .bus(bus), .zero_count(zc));
    fp16_zero_skip_encoder #(.CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .zero_count(zc2));
    int total = 0;
    int bad = 0;
    int zmodel = 0;
    logic [21:0] exp_q [$];
    logic [21:0] act_q [$];
    logic [15:0] brick [$];
    logic [15:0] bv [16];
    logic [21:0] held;
    bit held_v = 0;
    function automatic logic [21:0] head();
        return {bus.out_data, bus.out_offset, bus.out_last, bus.out_empty};
    endfunction
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    // Whole-brick model: nonzeros in order, last on the final one, marker if none
    task automatic model_accept(input logic [15:0] v);
        int last;
        brick.push_back(v);
        if (v[14:0] == 15'h0) zmodel++;
        if (brick.size() == 16) begin
            last = -1;
            for (int i = 0; i < 16; i++) if (brick[i][14:0] != 15'h0) last = i;
            if (last < 0) exp_q.push_back({16'h0, 4'h0, 2'b11});
            for (int i = 0; i < 16; i++)
                if (brick[i][14:0] != 15'h0) exp_q.push_back({brick[i], 4'(i), i == last, 1'b0});
            brick.delete();
        end
    endtask
    task automatic send(input logic [15:0] v, input bit rnd);
        logic ok;
        ok = 1'b0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        if (ok) model_accept(v);
        else chk("send_timeout", 32'(bus.in_ready), 1);
    endtask
    task automatic send_bv(input bit rnd);
        for (int i = 0; i < 16; i++) send(bv[i], rnd);
    endtask
    task automatic drain(input string tag);
        int n;
        bus.out_ready = 1'b1;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!bus.out_valid && act_q.size() >= exp_q.size()) break;
        end
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk({tag, "_entry"}, 32'(act_q[i]), 32'(exp_q[i]));
        act_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (rst) held_v = 0;
        else begin
            if (held_v && bus.out_valid) chk("stable", 32'(head()), 32'(held));
            held_v = bus.out_valid && !bus.out_ready;
            held = head();
            if (bus.out_valid && bus.out_ready) act_q.push_back(head());
        end
    end
    initial begin
        logic [15:0] v;
        bus.in_data = 16'h0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_data = 16'h0;
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 0);
        chk("post_rst_out", 32'(head()), 0);
        chk("post_rst_zc", zc, 0);
        @(posedge clk);
        #1;
        // 1: two nonzeros in a sparse brick
        for (int i = 0; i < 16; i++) bv[i] = 16'h0;
        bv[0] = 16'h3C00;
        bv[5] = 16'h4000;
        send_bv(0);
        drain("t1");
        chk("t1_zc", zc, 14);
        // 2: all-zero brick mixing +0 and -0
        for (int i = 0; i < 16; i++) bv[i] = (i % 2) ? 16'h8000 : 16'h0000;
        send_bv(0);
        drain("t2");
        chk("t2_zc", zc, 30);
        // 3: nonzeros at the last two positions force a FLUSH cycle
        for (int i = 0; i < 16; i++) bv[i] = 16'h0;
        bv[14] = 16'h3C00;
        bv[15] = 16'h4000;
        send_bv(0);
        @(negedge clk);
        chk("t3_flush_lo", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("t3_flush_hi", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        drain("t3");
        chk("t3_zc", zc, 44);
        // 4: backpressure fills the FIFO
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(16'h3C00 + 16'(i), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_in_ready_lo", 32'(bus.in_ready), 0);
            chk("t4_head", 32'(head()), 32'({16'h3C00, 4'h0, 2'b00}));
            chk("t4_out_valid", 32'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int i = 9; i < 16; i++) send(16'h3C00 + 16'(i), 0);
        drain("t4");
        chk("t4_zc", zc, 32'(zmodel));
        // 5: reset mid-brick
        send(16'h4400, 0);
        send(16'h0000, 0);
        send(16'h4500, 0);
        send(16'hC000, 0);
        send(16'h0000, 0);
        send(16'h4600, 0);
        send(16'h8000, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_out_valid", 32'(bus.out_valid), 0);
        chk("t5_zc", zc, 0);
        chk("t5_in_ready", 32'(bus.in_ready), 0);
        brick.delete();
        exp_q.delete();
        act_q.delete();
        zmodel = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) bv[i] = 16'h0;
        bv[0] = 16'hBC00;
        bv[3] = 16'h3800;
        bv[9] = 16'h0001;
        send_bv(0);
        drain("t5");
        chk("t5_zc_after", zc, 13);
        // random bricks with random backpressure
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < 16; i++) begin
                v = 16'($urandom);
                if ($urandom_range(0, 1) == 0) v = {v[15], 15'h0};
                else if (v[14:0] == 15'h0) v[0] = 1'b1;
                send(v, 1);
            end
        end
        drain("rand");
        chk("rand_zc", zc, 32'(zmodel));
        // 6: 4-bit counter saturates
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus2.in_data = (i % 2) ? 16'h8000 : 16'h0000;
            @(negedge clk);
            chk("t6_in_ready", 32'(bus2.in_ready), 1);
            @(posedge clk);
            #1;
            chk("t6_zc", 32'(zc2), (i + 1 > 15) ? 15 : i + 1);
        end
        bus2.in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
